// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the regfile write port from the ALU and mem producers.
// Optional macro WB_ROUND_ROBIN_EN switches producer arbitration from fixed mem priority to round-robin.
module wb_write_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_dest,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_dest,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     wb_stall,
  output logic                     reg_write_en,
  output logic [ADDR_W-1:0]        reg_write_dest,
  output logic [DATA_W-1:0]        reg_write_data,
  input  logic [ADDR_W-1:0]        query_addr,
  output logic                     query_hit,
  output logic [DATA_W-1:0]        query_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               alu_fire, mem_fire, push, pop;
  entry_t             push_ent;
  logic [PTR_W-1:0]   q_idx;

  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

`ifdef WB_ROUND_ROBIN_EN
  typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_e;
  grant_e last_grant_q, last_grant_d;

  // The producer granted last yields when both are requesting.
  assign mem_ready = !full && !(alu_valid && (last_grant_q == GRANT_MEM));
  assign alu_ready = !full && !(mem_valid && (last_grant_q == GRANT_ALU));

  always_comb begin
    last_grant_d = last_grant_q;
    if (mem_fire)      last_grant_d = GRANT_MEM;
    else if (alu_fire) last_grant_d = GRANT_ALU;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= GRANT_ALU;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
`endif

  assign alu_fire = alu_valid && alu_ready;
  assign mem_fire = mem_valid && mem_ready;

  // x0 writes complete the handshake but are never stored.
  assign push     = (mem_fire && (mem_dest != '0)) || (alu_fire && (alu_dest != '0));
  assign push_ent = mem_fire ? entry_t'{dest: mem_dest, data: mem_data}
                             : entry_t'{dest: alu_dest, data: alu_data};

  assign reg_write_en = !empty && !wb_stall && !rst;
  assign pop          = reg_write_en;

  always_comb begin
    reg_write_dest = '0;
    reg_write_data = '0;
    if (!empty) begin
      reg_write_dest = ent_q[rd_ptr_q].dest;
      reg_write_data = ent_q[rd_ptr_q].data;
    end
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    query_hit  = 1'b0;
    query_data = '0;
    q_idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      q_idx = rd_ptr_q + PTR_W'(i);
      if ((query_addr != '0) && vld_q[q_idx] && (ent_q[q_idx].dest == query_addr)) begin
        query_hit  = 1'b1;
        query_data = ent_q[q_idx].data;
      end
    end
  end

  always_comb begin
    ent_d    = ent_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      ent_d[wr_ptr_q] = push_ent;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: stimulus pushes expected regfile writes, a negedge monitor checks them.
module tb_wb_write_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 4;

  logic              clk, rst;
  logic              alu_valid, alu_ready, mem_valid, mem_ready;
  logic [ADDR_W-1:0] alu_dest, mem_dest, reg_write_dest, query_addr;
  logic [DATA_W-1:0] alu_data, mem_data, reg_write_data, query_data;
  logic              wb_stall, reg_write_en, query_hit, full, empty;
  logic [2:0]        count;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;

  wb_write_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .wb_stall(wb_stall),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
    .query_addr(query_addr), .query_hit(query_hit), .query_data(query_data),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: every regfile write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst) begin
      check("no_write_in_reset", 32'(reg_write_en), 32'd0);
    end else if (reg_write_en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_write: got dest %0d data 0x%0h, required no write",
                 reg_write_dest, reg_write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_dest", 32'(reg_write_dest), 32'(e.dest));
        check("wr_data", reg_write_data, e.data);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit use_mem, input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
    int n = 0;
    if (use_mem) begin mem_valid = 1'b1; mem_dest = d; mem_data = v; end
    else         begin alu_valid = 1'b1; alu_dest = d; alu_data = v; end
    forever begin
      @(negedge clk);
      if (use_mem ? mem_ready : alu_ready) break;
      n++;
      if (n > 64) begin
        n_chk++;
        n_err++;
        $display("FAIL send_timeout: dest %0d got ready=0 for 64 cycles, required 1", d);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (use_mem) mem_valid = 1'b0;
    else         alu_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wb_stall = 1'b0; query_addr = '0;
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_empty",     32'(empty),          32'd1);
    check("rst_full",      32'(full),           32'd0);
    check("rst_count",     32'(count),          32'd0);
    check("rst_wen",       32'(reg_write_en),   32'd0);
    check("rst_wdest",     32'(reg_write_dest), 32'd0);
    check("rst_wdata",     reg_write_data,      32'd0);
    check("rst_qhit",      32'(query_hit),      32'd0);
    check("rst_qdata",     query_data,          32'd0);
    check("rst_alu_ready", 32'(alu_ready),      32'd1);
    check("rst_mem_ready", 32'(mem_ready),      32'd1);

    // Single ALU write, one-cycle latency
    cyc(1);
    exp_q.push_back(wr_t'{dest: 5'd5, data: 32'h1234_5678});
    send(1'b0, 5'd5, 32'h1234_5678);
    @(negedge clk);
    check("t1_wen_latency", 32'(reg_write_en), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("t1_empty_after", 32'(empty), 32'd1);

    // Both producers valid: mem wins, drains 4 then 3
    cyc(1);
    exp_q.push_back(wr_t'{dest: 5'd4, data: 32'h0000_BBBB});
    exp_q.push_back(wr_t'{dest: 5'd3, data: 32'h0000_AAAA});
    alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h0000_AAAA;
    mem_valid = 1'b1; mem_dest = 5'd4; mem_data = 32'h0000_BBBB;
    @(negedge clk);
    check("t2_mem_ready", 32'(mem_ready), 32'd1);
    check("t2_alu_wait",  32'(alu_ready), 32'd0);
    @(posedge clk); #1 mem_valid = 1'b0;
    @(negedge clk);
    check("t2_alu_ready", 32'(alu_ready), 32'd1);
    @(posedge clk); #1 alu_valid = 1'b0;
    cyc(3);
    check("t2_empty", 32'(empty), 32'd1);

    // Stall fills the queue; fifth request waits, then drains in order
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(wr_t'{dest: 5'(10 + i), data: 32'(32'hA0 + i)});
      send(1'b0, 5'(10 + i), 32'(32'hA0 + i));
    end
    @(negedge clk);
    check("t3_full",      32'(full),      32'd1);
    check("t3_count",     32'(count),     32'd4);
    check("t3_alu_ready", 32'(alu_ready), 32'd0);
    check("t3_mem_ready", 32'(mem_ready), 32'd0);
    exp_q.push_back(wr_t'{dest: 5'd14, data: 32'h0000_00A4});
    alu_valid = 1'b1; alu_dest = 5'd14; alu_data = 32'h0000_00A4;
    repeat (3) begin
      @(negedge clk);
      check("t3_ready_while_full", 32'(alu_ready), 32'd0);
    end
    @(posedge clk); #1 wb_stall = 1'b0;
    send(1'b0, 5'd14, 32'h0000_00A4);
    cyc(8);
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_sb_drained", 32'(exp_q.size()), 32'd0);

    // x0 write is accepted but never stored
    alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t4_alu_ready", 32'(alu_ready), 32'd1);
    @(posedge clk); #1 alu_valid = 1'b0;
    @(negedge clk);
    check("t4_count", 32'(count),        32'd0);
    check("t4_empty", 32'(empty),        32'd1);
    check("t4_wen",   32'(reg_write_en), 32'd0);
    cyc(2);

    // Query returns youngest match
    wb_stall = 1'b1;
    exp_q.push_back(wr_t'{dest: 5'd7, data: 32'h11});
    exp_q.push_back(wr_t'{dest: 5'd7, data: 32'h22});
    send(1'b0, 5'd7, 32'h11);
    send(1'b1, 5'd7, 32'h22);
    query_addr = 5'd7; #1;
    check("t5_hit7",   32'(query_hit), 32'd1);
    check("t5_data7",  query_data,     32'h22);
    query_addr = 5'd0; #1;
    check("t5_hit0",   32'(query_hit), 32'd0);
    check("t5_data0",  query_data,     32'd0);
    query_addr = 5'd8; #1;
    check("t5_hit8",   32'(query_hit), 32'd0);
    query_addr = 5'd7;
    @(posedge clk); #1 wb_stall = 1'b0;
    @(negedge clk);
    check("t5_head_wen",  32'(reg_write_en), 32'd1);
    check("t5_head_hit",  32'(query_hit),    32'd1);
    check("t5_head_data", query_data,        32'h22);
    cyc(4);
    check("t5_empty", 32'(empty), 32'd1);

    // Reset mid-operation discards queued entries
    wb_stall = 1'b1;
    exp_q.push_back(wr_t'{dest: 5'd1, data: 32'h101});
    exp_q.push_back(wr_t'{dest: 5'd2, data: 32'h202});
    exp_q.push_back(wr_t'{dest: 5'd9, data: 32'h909});
    send(1'b0, 5'd1, 32'h101);
    send(1'b1, 5'd2, 32'h202);
    send(1'b0, 5'd9, 32'h909);
    @(negedge clk);
    check("t6_count3", 32'(count), 32'd3);
    query_addr = 5'd9;
    @(posedge clk);
    #1 rst = 1'b1; wb_stall = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_count", 32'(count),        32'd0);
    check("t6_empty", 32'(empty),        32'd1);
    check("t6_wen",   32'(reg_write_en), 32'd0);
    check("t6_qhit",  32'(query_hit),    32'd0);
    cyc(3);
    check("final_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
